// File: rtl/lsu_ctrl_pkg.sv
// Shared constants, payload types and request checks for the load/store unit.
package lsu_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 3;

  // RV32 funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [STRB_W-1:0] STRB_NONE = 4'b0000;
  localparam logic [STRB_W-1:0] STRB_B0   = 4'b0001;
  localparam logic [STRB_W-1:0] STRB_LO   = 4'b0011;
  localparam logic [STRB_W-1:0] STRB_HI   = 4'b1100;
  localparam logic [STRB_W-1:0] STRB_ALL  = 4'b1111;

  typedef struct packed {
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
  } dmem_wr_t;

  // Illegal funct3 for the direction, or address not aligned to the access size
  function automatic logic req_err(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] lane);
    logic bad_f3;
    logic misalign;
    bad_f3   = we ? (funct3 >= 3'b011) : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    misalign = ((funct3[1:0] == 2'b01) && lane[0]) ||
               ((funct3[1:0] == 2'b10) && (lane != 2'b00));
    return bad_f3 | misalign;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store strobe/lane replication and load lane extract/extend; purely combinational.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output dmem_wr_t          wr_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [4:0]        sh_amt;
  logic [DATA_W-1:0] shifted;

  assign sh_amt  = {lane, 3'b000};
  assign shifted = rdata >> sh_amt;

  always_comb begin
    wr_c.strb = STRB_NONE;
    wr_c.data = wdata;
    case (funct3[1:0])
      2'b00: begin
        wr_c.strb = STRB_B0 << lane;
        wr_c.data = {4{wdata[7:0]}};
      end
      2'b01: begin
        wr_c.strb = lane[1] ? STRB_HI : STRB_LO;
        wr_c.data = {2{wdata[15:0]}};
      end
      2'b10:   wr_c.strb = STRB_ALL;
      default: wr_c.strb = STRB_NONE;
    endcase
  end

  always_comb begin
    rdata_c = '0;
    case (funct3)
      F3_B:    rdata_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_c = rdata;
      F3_BU:   rdata_c = {24'h0, shifted[7:0]};
      F3_HU:   rdata_c = {16'h0, shifted[15:0]};
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one request, drives data_mem, returns a one-cycle response.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DMEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] addr_dmem_o,
  output logic [DATA_W-1:0] wr_data_dmem_o,
  output logic [STRB_W-1:0] wr_strb_dmem_o,
  output logic              wr_en_dmem_o,
  input  logic [DATA_W-1:0] rd_data_dmem_i
);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_d;
  logic [ADDR_W-1:0] addr_dmem_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [STRB_W-1:0] wr_strb_d;
  logic              wr_en_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;

  logic [2:0]        al_f3;
  logic [1:0]        al_lane;
  dmem_wr_t          al_wr;
  logic [DATA_W-1:0] al_rdata;

  // In IDLE the aligner sees the incoming request so dmem outputs register at accept
  assign al_f3   = (state_q == ST_IDLE) ? req_funct3_i : f3_q;
  assign al_lane = (state_q == ST_IDLE) ? req_addr_i[1:0] : lane_q;

  lsu_align u_align (
    .funct3  (al_f3),
    .lane    (al_lane),
    .wdata   (req_wdata_i),
    .rdata   (rd_data_dmem_i),
    .wr_c    (al_wr),
    .rdata_c (al_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      lane_q         <= 2'b00;
      cnt_q          <= '0;
      req_ready_o    <= 1'b0;
      addr_dmem_o    <= '0;
      wr_data_dmem_o <= '0;
      wr_strb_dmem_o <= STRB_NONE;
      wr_en_dmem_o   <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      f3_q           <= f3_d;
      lane_q         <= lane_d;
      cnt_q          <= cnt_d;
      req_ready_o    <= ready_d;
      addr_dmem_o    <= addr_dmem_d;
      wr_data_dmem_o <= wr_data_d;
      wr_strb_dmem_o <= wr_strb_d;
      wr_en_dmem_o   <= wr_en_d;
      rsp_valid_o    <= rsp_valid_d;
      rsp_rdata_o    <= rsp_rdata_d;
      rsp_err_o      <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    addr_dmem_d = addr_dmem_o;
    wr_data_d   = wr_data_dmem_o;
    wr_strb_d   = STRB_NONE;
    wr_en_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          we_d   = req_we_i;
          f3_d   = req_funct3_i;
          lane_d = req_addr_i[1:0];
          if (req_err(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            addr_dmem_d = {req_addr_i[ADDR_W-1:2], 2'b00};
            wr_en_d     = req_we_i;
            if (req_we_i) begin
              wr_data_d = al_wr.data;
              wr_strb_d = al_wr.strb;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(DMEM_LAT);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Read word is valid in the last wait cycle
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = al_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl at DMEM_LAT=1 (dut 0) and DMEM_LAT=3 (dut 1).
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        valid     [2];
  logic        ready     [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] addr_dmem [2];
  logic [31:0] wr_data   [2];
  logic [3:0]  wr_strb   [2];
  logic        wr_en     [2];
  logic [31:0] rd_data   [2];

  logic [31:0] mem [16];
  logic [31:0] p1, p3a, p3b, p3c;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  int          wr_cnt [2];
  int          wr_cyc [2];
  logic [31:0] wr_addr_s [2];
  logic [31:0] wr_data_s [2];
  logic [3:0]  wr_strb_s [2];
  int          rsp_cnt [2];
  int          rsp_cyc [2];
  logic [31:0] rsp_data_s [2];
  logic        rsp_err_s [2];
  int          bad_idle [2];

  lsu_ctrl #(.ADDR_W(32), .DMEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
    .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]),
    .addr_dmem_o(addr_dmem[0]), .wr_data_dmem_o(wr_data[0]), .wr_strb_dmem_o(wr_strb[0]),
    .wr_en_dmem_o(wr_en[0]), .rd_data_dmem_i(rd_data[0])
  );

  lsu_ctrl #(.ADDR_W(32), .DMEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
    .req_we_i(we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]),
    .addr_dmem_o(addr_dmem[1]), .wr_data_dmem_o(wr_data[1]), .wr_strb_dmem_o(wr_strb[1]),
    .wr_en_dmem_o(wr_en[1]), .rd_data_dmem_i(rd_data[1])
  );

  // Synchronous-read memory models with one and three cycles of latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= mem[addr_dmem[0][5:2]];
    p3a <= mem[addr_dmem[1][5:2]];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign rd_data[0] = p1;
  assign rd_data[1] = p3c;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        wr_cnt[i]    <= wr_cnt[i] + 1;
        wr_cyc[i]    <= cyc;
        wr_addr_s[i] <= addr_dmem[i];
        wr_data_s[i] <= wr_data[i];
        wr_strb_s[i] <= wr_strb[i];
      end
      if (rsp_valid[i]) begin
        rsp_cnt[i]    <= rsp_cnt[i] + 1;
        rsp_cyc[i]    <= cyc;
        rsp_data_s[i] <= rsp_rdata[i];
        rsp_err_s[i]  <= rsp_err[i];
      end else if (rsp_rdata[i] != 32'h0 || rsp_err[i]) begin
        bad_idle[i] <= bad_idle[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request on dut d and return its accept cycle; leaves time at accept+1 cycle
  task automatic issue(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, output int t);
    @(posedge clk); #1;
    we = w; f3 = f; addr = a; wdata = wd; valid[d] = 1'b1;
    t = -1;
    for (int k = 0; k < 30 && t < 0; k++) begin
      @(negedge clk);
      if (ready[d]) t = cyc;
    end
    if (t < 0) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  task automatic txn(input string tag, input int d, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wd, input int lat,
                     input logic [3:0] e_strb, input logic [31:0] e_wdata,
                     input logic [31:0] e_rdata, input logic e_err);
    int t, w0, r0, e_wr;
    w0 = wr_cnt[d];
    r0 = rsp_cnt[d];
    e_wr = (w && !e_err) ? 1 : 0;
    issue(d, w, f, a, wd, t);
    while (cyc <= t + lat + 1) begin @(posedge clk); #1; end
    chk({tag, "_rsp_n"}, 32'(rsp_cnt[d] - r0), 32'h1);
    chk({tag, "_lat"},   32'(rsp_cyc[d] - t), 32'(lat));
    chk({tag, "_rdata"}, rsp_data_s[d], e_rdata);
    chk({tag, "_err"},   32'(rsp_err_s[d]), 32'(e_err));
    chk({tag, "_wr_n"},  32'(wr_cnt[d] - w0), 32'(e_wr));
    if (e_wr != 0) begin
      chk({tag, "_wr_cyc"},  32'(wr_cyc[d] - t), 32'h1);
      chk({tag, "_wr_addr"}, wr_addr_s[d], a & 32'hFFFF_FFFC);
      chk({tag, "_wr_strb"}, 32'(wr_strb_s[d]), 32'(e_strb));
      chk({tag, "_wr_data"}, wr_data_s[d], e_wdata);
    end
  endtask

  // Hold valid high for three loads and measure the accept spacing
  task automatic held(input string tag, input int d, input int lat);
    int acc[3];
    int n, lowcnt, r0;
    acc = '{0, 0, 0};
    n = 0; lowcnt = 0; r0 = rsp_cnt[d];
    @(posedge clk); #1;
    we = 1'b0; f3 = F3_W; addr = 32'h10; wdata = 32'h0; valid[d] = 1'b1;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (ready[d]) begin acc[n] = cyc; n++; end
      else if (n == 1) lowcnt++;
    end
    @(posedge clk); #1;
    valid[d] = 1'b0;
    repeat (lat + 4) @(posedge clk);
    #1;
    chk({tag, "_accepts"}, 32'(n), 32'h3);
    chk({tag, "_gap1"}, 32'(acc[1] - acc[0]), 32'(3 + lat));
    chk({tag, "_gap2"}, 32'(acc[2] - acc[1]), 32'(3 + lat));
    chk({tag, "_ready_low"}, 32'(lowcnt), 32'(2 + lat));
    chk({tag, "_rsp_n"}, 32'(rsp_cnt[d] - r0), 32'h3);
    chk({tag, "_lat"}, 32'(rsp_cyc[d] - acc[2]), 32'(2 + lat));
    chk({tag, "_rdata"}, rsp_data_s[d], 32'h80FF7F01);
  endtask

  initial begin
    int t, w0, r0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h80FF7F01;
    rst = 1'b0; valid[0] = 1'b0; valid[1] = 1'b0;
    we = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(ready[0]), 32'h0);
    chk("rst_wr_en",   32'(wr_en[0]), 32'h0);
    chk("rst_rsp",     32'(rsp_valid[0]), 32'h0);
    chk("rst_addr",    addr_dmem[0], 32'h0);
    chk("rst_strb",    32'(wr_strb[0]), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(ready[0]), 32'h1);

    // Stores
    txn("sw",   0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 2, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("sb13", 0, 1'b1, F3_B, 32'h13, 32'h000000A5, 2, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0);
    txn("sh12", 0, 1'b1, F3_H, 32'h12, 32'h00001234, 2, 4'b1100, 32'h12341234, 32'h0, 1'b0);
    txn("sh10", 0, 1'b1, F3_H, 32'h10, 32'hABCD5678, 2, 4'b0011, 32'h56785678, 32'h0, 1'b0);
    txn("sb11", 0, 1'b1, F3_B, 32'h11, 32'h0000003C, 2, 4'b0010, 32'h3C3C3C3C, 32'h0, 1'b0);

    // Loads from 0x80FF7F01
    txn("lb13",  0, 1'b0, F3_B,  32'h13, 32'h0, 3, 4'b0, 32'h0, 32'hFFFFFF80, 1'b0);
    txn("lbu13", 0, 1'b0, F3_BU, 32'h13, 32'h0, 3, 4'b0, 32'h0, 32'h00000080, 1'b0);
    txn("lh12",  0, 1'b0, F3_H,  32'h12, 32'h0, 3, 4'b0, 32'h0, 32'hFFFF80FF, 1'b0);
    txn("lhu10", 0, 1'b0, F3_HU, 32'h10, 32'h0, 3, 4'b0, 32'h0, 32'h00007F01, 1'b0);
    txn("lw10",  0, 1'b0, F3_W,  32'h10, 32'h0, 3, 4'b0, 32'h0, 32'h80FF7F01, 1'b0);
    txn("lb11",  0, 1'b0, F3_B,  32'h11, 32'h0, 3, 4'b0, 32'h0, 32'h0000007F, 1'b0);

    // Errors: misaligned and illegal funct3
    txn("e_lw0e",  0, 1'b0, F3_W,   32'h0E, 32'h0, 1, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("e_sh11",  0, 1'b1, F3_H,   32'h11, 32'hFFFF, 1, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("e_ld011", 0, 1'b0, 3'b011, 32'h10, 32'h0, 1, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("e_st100", 0, 1'b1, 3'b100, 32'h10, 32'h1, 1, 4'b0, 32'h0, 32'h0, 1'b1);

    // Back-to-back with valid held, both latencies
    held("held1", 0, 1);
    held("held3", 1, 3);
    txn("lat3_lb13", 1, 1'b0, F3_B, 32'h13, 32'h0, 5, 4'b0, 32'h0, 32'hFFFFFF80, 1'b0);

    // Reset during the WAIT of a load
    r0 = rsp_cnt[0];
    issue(0, 1'b0, F3_W, 32'h10, 32'h0, t);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstw_ready", 32'(ready[0]), 32'h0);
    chk("rstw_rsp",   32'(rsp_valid[0]), 32'h0);
    chk("rstw_addr",  addr_dmem[0], 32'h0);
    @(negedge clk); rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rstw_rsp_n", 32'(rsp_cnt[0] - r0), 32'h0);

    // Reset during the ACCESS of a store
    r0 = rsp_cnt[0];
    w0 = wr_cnt[0];
    issue(0, 1'b1, F3_W, 32'h10, 32'h12345678, t);
    chk("rsts_pre_wr", 32'(wr_en[0]), 32'h1);
    rst = 1'b0;
    #1;
    chk("rsts_wr_en", 32'(wr_en[0]), 32'h0);
    chk("rsts_strb",  32'(wr_strb[0]), 32'h0);
    chk("rsts_data",  wr_data[0], 32'h0);
    @(negedge clk); rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rsts_wr_n",  32'(wr_cnt[0] - w0), 32'h0);
    chk("rsts_rsp_n", 32'(rsp_cnt[0] - r0), 32'h0);
    chk("post_rst_ready", 32'(ready[0]), 32'h1);

    chk("quiet_rsp_dut1", 32'(bad_idle[0]), 32'h0);
    chk("quiet_rsp_dut3", 32'(bad_idle[1]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
